pipelined_cla_adder: RTL and testbench
======================================

# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups, with one register boundary every `GROUPS_PER_STAGE` groups and a valid/ready handshake on both sides. It sits in the datapath wherever a wide add or subtract must meet timing that a single-cycle ripple of lookahead groups cannot. Full back-pressure is supported.

## Interface
- `WIDTH`, 16: operand width in bits; must be a multiple of 4, minimum 4.
- `GROUPS_PER_STAGE`, 1: 4-bit groups evaluated per pipeline stage; minimum 1.
- Derived `NGROUPS = WIDTH/4` and `LAT = ceil(NGROUPS/GROUPS_PER_STAGE)`.
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  block accepts the beat this cycle.
- `A`, `B`  in  WIDTH  operands.
- `Cin`  in  1  carry in; used only when `sub`=0.
- `sub`  in  1  0: S = A+B+Cin; 1: S = A+~B+1 (A−B), `Cin` ignored.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `S`  out  WIDTH  sum/difference, modulo 2^WIDTH.
- `Cout`  out  1  raw carry out of MSB (for subtract: 1 = no borrow).
- `Ovf`  out  1  two's-complement signed overflow.

## Operation
- Group k covers bits [4k+3:4k]; group propagate/generate, per-bit sum, and group carry-out as `g | (c_in & p)` at every bit.
- Stage j (0..LAT-1) evaluates groups j·GPS .. min((j+1)·GPS, NGROUPS)−1, using the carry registered from stage j−1 (stage 0 uses the effective carry in).
- Effective B' = `sub` ? ~B : B; effective carry in = `sub` ? 1 : `Cin`; computed before stage 0, combinationally.
- Unprocessed upper bits of A and B' travel with the beat; finished S bits are carried forward, so each stage register holds: valid, carry, partial S, remaining A/B', and MSB signs for overflow.
- `Ovf` = (A[MSB] == B'[MSB]) && (S[MSB] != A[MSB]).
- Global stall: `advance = !out_valid || out_ready`; `in_ready = advance`. When `advance`=0, every stage register holds. When `advance`=1, every stage shifts one step; a stage with valid=0 is a bubble and shifts as such (no bubble collapse).
- Beat accepted iff `in_valid && in_ready`; otherwise stage-0 valid is loaded 0.
- Results emerge strictly in acceptance order; no reordering, no drops, no duplicates.

## Timing
- Latency: a beat accepted in cycle t has `out_valid`=1 at cycle t+LAT, absent stalls; each stall cycle adds one.
- Throughput: one beat per cycle while `out_ready` stays 1.
- `in_ready` is combinational from `out_valid` and `out_ready`; no combinational path from `in_valid` to `in_ready`.
- `S`, `Cout`, `Ovf` stable while `out_valid`=1 and `out_ready`=0.
- Reset (any time, including mid-operation): all stage valids 0, `out_valid`=0, `S`=0, `Cout`=0, `Ovf`=0; in-flight beats discarded; `in_ready`=1 during and after reset.
- Simultaneous output acceptance and input acceptance in one cycle is legal and keeps full throughput.
- The last stage may hold fewer than `GROUPS_PER_STAGE` groups when NGROUPS is not a multiple.

## Structure
- Shared package: `CLA_GROUP_W` = 4 and a function returning LAT from WIDTH and GROUPS_PER_STAGE.
- Sub-module `cla_group4`: combinational 4-bit lookahead group (A, B, cin → S, cout); instantiated NGROUPS times via generate.
- Stage registers and handshake live in `pipelined_cla_adder`.

## Test plan
- WIDTH=16, GPS=1 (LAT=4): A=0x1234, B=0x1111, Cin=1, sub=0 → S=0x2346, Cout=0, Ovf=0, 4 cycles after acceptance.
- Subtract: A=0x0005, B=0x0007, sub=1 → S=0xFFFE, Cout=0, Ovf=0; A=0x8000, B=0x0001, sub=1 → S=0x7FFF, Cout=1, Ovf=1.
- Full carry chain: A=0xFFFF, B=0x0000, Cin=1 → S=0x0000, Cout=1; A=0x7FFF, B=0x0001 → S=0x8000, Ovf=1.
- Back-pressure: stream 8 random beats with `out_ready` toggling 1,0,0,1,… → all 8 results match reference model, in order; `in_ready`=0 exactly on cycles with `out_valid`=1 and `out_ready`=0.
- Reset mid-stream with 3 beats in flight → `out_valid`=0 next cycle, none of the 3 ever appear; next accepted beat emerges after exactly LAT cycles.
- Parameter sweep WIDTH ∈ {4, 12, 32}, GPS ∈ {1, 2, 3}: 1000 random beats per configuration with random stalls → zero mismatches; measured latency equals LAT.

Source files
------------

// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
// LAT is the number of register stages a beat passes through.
package pipelined_cla_adder_pkg;

    localparam int CLA_GROUP_W = 4;

    function automatic int calc_lat(input int width, input int groups_per_stage);
        int ngroups;
        ngroups = width / CLA_GROUP_W;
        return (ngroups + groups_per_stage - 1) / groups_per_stage;
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result stream of the pipelined adder. The master side drives operands
// and consumes results. The slave side is the adder.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Cin, sub, out_ready,
        input  in_ready, out_valid, S, Cout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, sub, out_ready,
        output in_ready, out_valid, S, Cout, Ovf
    );
endinterface

// File: rtl/pipelined_cla_adder_cla_group4.sv
// Combinational 4-bit carry-lookahead group: every internal carry and the group
// carry-out are flattened from the bit generate/propagate terms.
module cla_group4
    import pipelined_cla_adder_pkg::*;
(
    input  logic [CLA_GROUP_W-1:0] i_a,
    input  logic [CLA_GROUP_W-1:0] i_b,
    input  logic                   i_cin,
    output logic [CLA_GROUP_W-1:0] o_s,
    output logic                   o_cout
);
    logic [CLA_GROUP_W-1:0] w_p;
    logic [CLA_GROUP_W-1:0] w_g;
    logic [CLA_GROUP_W:0]   w_c;
    logic                   w_grp_p;
    logic                   w_grp_g;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    assign w_grp_p = &w_p;
    assign w_grp_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_grp_g | (w_grp_p & i_cin);

    assign o_s    = w_p ^ w_c[CLA_GROUP_W-1:0];
    assign o_cout = w_c[CLA_GROUP_W];
endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder/subtractor: GROUPS_PER_STAGE lookahead groups per register stage.
// A single global stall freezes every stage while the output is held.
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int GROUPS_PER_STAGE = 1
) (
    input logic                 clk,
    input logic                 rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int NGROUPS = WIDTH / CLA_GROUP_W;
    localparam int LAT     = calc_lat(WIDTH, GROUPS_PER_STAGE);

    logic             w_advance;
    logic             w_accept;
    logic             w_cin_eff;
    logic [WIDTH-1:0] w_b_eff;

    // Inputs seen by each stage: the stage-0 entries come from the bus, the rest from the previous register.
    logic [WIDTH-1:0] w_in_a [LAT];
    logic [WIDTH-1:0] w_in_b [LAT];
    logic [WIDTH-1:0] w_in_s [LAT];
    logic [LAT-1:0]   w_in_c;
    logic [LAT-1:0]   w_in_amsb;
    logic [LAT-1:0]   w_in_bmsb;
    logic [WIDTH-1:0] w_nx_s [LAT];
    logic [LAT-1:0]   w_nx_c;

    logic [CLA_GROUP_W-1:0] w_gs [NGROUPS];
    logic [NGROUPS-1:0]     w_gc;
    logic [NGROUPS-1:0]     w_gcin;

    logic [LAT-1:0]   r_valid;
    logic [LAT-1:0]   r_c;
    logic [LAT-1:0]   r_amsb;
    logic [LAT-1:0]   r_bmsb;
    logic [WIDTH-1:0] r_a [LAT];
    logic [WIDTH-1:0] r_b [LAT];
    logic [WIDTH-1:0] r_s [LAT];

    assign w_advance = !r_valid[LAT-1] || bus.out_ready;
    assign w_accept  = bus.in_valid && w_advance;
    assign w_b_eff   = bus.sub ? ~bus.B : bus.B;
    assign w_cin_eff = bus.sub ? 1'b1 : bus.Cin;

    always_comb begin
        // NOTE: every element is assigned on every pass, so no latch is inferred.
        w_in_a[0]    = bus.A;
        w_in_b[0]    = w_b_eff;
        w_in_s[0]    = '0;
        w_in_c[0]    = w_cin_eff;
        w_in_amsb[0] = bus.A[WIDTH-1];
        w_in_bmsb[0] = w_b_eff[WIDTH-1];
        for (int j = 1; j < LAT; j++) begin
            w_in_a[j]    = r_a[j-1];
            w_in_b[j]    = r_b[j-1];
            w_in_s[j]    = r_s[j-1];
            w_in_c[j]    = r_c[j-1];
            w_in_amsb[j] = r_amsb[j-1];
            w_in_bmsb[j] = r_bmsb[j-1];
        end
    end

    for (genvar k = 0; k < NGROUPS; k++) begin : g_group
        localparam int J = k / GROUPS_PER_STAGE;

        if (k % GROUPS_PER_STAGE == 0) begin : g_first
            assign w_gcin[k] = w_in_c[J];
        end else begin : g_chain
            assign w_gcin[k] = w_gc[k-1];
        end

        if ((k % GROUPS_PER_STAGE == GROUPS_PER_STAGE - 1) || (k == NGROUPS - 1)) begin : g_last
            assign w_nx_c[J] = w_gc[k];
        end

        cla_group4 u_group (
            .i_a    (w_in_a[J][CLA_GROUP_W*k +: CLA_GROUP_W]),
            .i_b    (w_in_b[J][CLA_GROUP_W*k +: CLA_GROUP_W]),
            .i_cin  (w_gcin[k]),
            .o_s    (w_gs[k]),
            .o_cout (w_gc[k])
        );
    end

    // Each stage overwrites only its own groups of the partial sum it inherited.
    always_comb begin
        for (int j = 0; j < LAT; j++) begin
            w_nx_s[j] = w_in_s[j];
            for (int k = 0; k < NGROUPS; k++) begin
                if (k / GROUPS_PER_STAGE == j) begin
                    w_nx_s[j][CLA_GROUP_W*k +: CLA_GROUP_W] = w_gs[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: datapath registers are reset too, so S/Cout/Ovf read 0 after reset rather than a stale sum.
            r_valid <= '0;
            r_c     <= '0;
            r_amsb  <= '0;
            r_bmsb  <= '0;
            for (int j = 0; j < LAT; j++) begin
                r_a[j] <= '0;
                r_b[j] <= '0;
                r_s[j] <= '0;
            end
        end else if (w_advance) begin
            r_valid[0] <= w_accept;
            for (int j = 1; j < LAT; j++) begin
                r_valid[j] <= r_valid[j-1];
            end
            for (int j = 0; j < LAT; j++) begin
                r_a[j]    <= w_in_a[j];
                r_b[j]    <= w_in_b[j];
                r_s[j]    <= w_nx_s[j];
                r_c[j]    <= w_nx_c[j];
                r_amsb[j] <= w_in_amsb[j];
                r_bmsb[j] <= w_in_bmsb[j];
            end
        end
    end

    assign bus.in_ready  = w_advance;
    assign bus.out_valid = r_valid[LAT-1];
    assign bus.S         = r_s[LAT-1];
    assign bus.Cout      = r_c[LAT-1];
    assign bus.Ovf       = (r_amsb[LAT-1] == r_bmsb[LAT-1]) && (r_s[LAT-1][WIDTH-1] != r_amsb[LAT-1]);
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench: directed vectors, back-pressure, mid-stream reset and a
// parameter sweep, all checked against an integer-arithmetic reference model.
module tb_pipelined_cla_adder;

    localparam int LAT16 = 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        bit          cin;
        bit          sub;
        logic [15:0] s;
        bit          cout;
        bit          ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic sweep_go = 1'b0;
    int   sw_done_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    vec_t vecs [5] = '{
        '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0},
        '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
        '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
        '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0},
        '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1}
    };

    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(16)) bus16 ();

    pipelined_cla_adder #(.WIDTH(16), .GROUPS_PER_STAGE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    // Reference: {Ovf, Cout, S zero-extended to 32 bits}, from plain integer arithmetic.
    function automatic logic [33:0] ref_model(input int w, input longint a, input longint b,
                                              input bit cin, input bit sub);
        longint     mask;
        longint     half;
        longint     sa;
        longint     sb;
        longint     ures;
        longint     sres;
        logic [33:0] r;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sa   = (a >= half) ? a - (mask + 1) : a;
        sb   = (b >= half) ? b - (mask + 1) : b;
        if (sub) begin
            ures = a + ((~b) & mask) + 1;
            sres = sa - sb;
        end else begin
            ures = a + b + longint'(cin);
            sres = sa + sb + longint'(cin);
        end
        r        = '0;
        r[31:0]  = 32'(ures & mask);
        r[32]    = ((ures >> w) & 1) != 0;
        r[33]    = (sres >= half) || (sres < -half);
        return r;
    endfunction

    task automatic idle16();
        bus16.in_valid  = 1'b0;
        bus16.A         = '0;
        bus16.B         = '0;
        bus16.Cin       = 1'b0;
        bus16.sub       = 1'b0;
        bus16.out_ready = 1'b1;
    endtask

    // Sends one beat into an empty pipe; returns the result and cycles until out_valid (-1 on timeout).
    task automatic run_one(input logic [15:0] a, input logic [15:0] b, input bit cin, input bit sub,
                           output logic [33:0] got, output int lat);
        @(negedge clk);
        bus16.in_valid  = 1'b1;
        bus16.A         = a;
        bus16.B         = b;
        bus16.Cin       = cin;
        bus16.sub       = sub;
        bus16.out_ready = 1'b1;
        lat = -1;
        got = '0;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            #1;
            if (bus16.out_valid) begin
                lat = n;
                got = {bus16.Ovf, bus16.Cout, 16'h0000, bus16.S};
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle16();
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({bus16.out_valid, bus16.Cout, bus16.Ovf, bus16.S} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_outputs during: got valid=%b cout=%b ovf=%b s=%h required all 0",
                     bus16.out_valid, bus16.Cout, bus16.Ovf, bus16.S);
        end
        n_checks++;
        if (bus16.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready during: got %b required 1", bus16.in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus16.out_valid, bus16.Cout, bus16.Ovf, bus16.S} !== 19'h0 || bus16.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_after: got valid=%b cout=%b ovf=%b s=%h ready=%b required 0/0/0/0000/1",
                     bus16.out_valid, bus16.Cout, bus16.Ovf, bus16.S, bus16.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [33:0] got;
        logic [33:0] exp;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run_one(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, got, lat);
            exp = {vecs[i].ovf, vecs[i].cout, 16'h0000, vecs[i].s};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL directed_%0d value: got ovf/cout/s=%b/%b/%h required %b/%b/%h",
                         i, got[33], got[32], got[15:0], exp[33], exp[32], exp[15:0]);
            end
            n_checks++;
            if (lat != LAT16) begin
                n_fail++;
                $display("FAIL directed_%0d latency: got %0d required %0d", i, lat, LAT16);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] expq [$];
        logic [33:0] got;
        logic [33:0] exp;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int          sent = 0;
        int          got_n = 0;
        int          cyc = 0;
        while (got_n < 8 && cyc < 200) begin
            @(negedge clk);
            ra = $urandom;
            rb = $urandom;
            bus16.in_valid  = (sent < 8);
            bus16.A         = ra[15:0];
            bus16.B         = rb[15:0];
            bus16.Cin       = 1'($urandom_range(1));
            bus16.sub       = 1'($urandom_range(1));
            bus16.out_ready = pat[cyc % 4];
            #1;
            n_checks++;
            if (bus16.in_ready !== !(bus16.out_valid && !bus16.out_ready)) begin
                n_fail++;
                $display("FAIL b2b_in_ready cycle %0d: got %b with out_valid=%b out_ready=%b",
                         cyc, bus16.in_ready, bus16.out_valid, bus16.out_ready);
            end
            if (bus16.out_valid && bus16.out_ready) begin
                n_checks++;
                got = {bus16.Ovf, bus16.Cout, 16'h0000, bus16.S};
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_order: got unexpected result %h required none", got);
                end else begin
                    exp = expq.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL b2b_value beat %0d: got %h required %h", got_n, got, exp);
                    end
                end
                got_n++;
            end
            if (bus16.in_valid && bus16.in_ready) begin
                expq.push_back(ref_model(16, longint'(bus16.A), longint'(bus16.B), bus16.Cin, bus16.sub));
                sent++;
            end
            cyc++;
        end
        n_checks++;
        if (got_n != 8) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results required 8", got_n);
        end
        @(negedge clk);
        idle16();
    endtask

    task automatic test_reset_midstream();
        logic [31:0] ra;
        logic [31:0] rb;
        logic [33:0] got;
        logic [33:0] exp;
        int          lat;
        int          seen = 0;
        @(negedge clk);
        idle16();
        repeat (LAT16 + 1) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            bus16.in_valid = 1'b1;
            bus16.A        = ra[15:0];
            bus16.B        = rb[15:0];
            @(negedge clk);
        end
        bus16.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_during: got valid=%b ready=%b required 0/1", bus16.out_valid, bus16.in_ready);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus16.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_next_cycle: got valid=%b required 0", bus16.out_valid);
        end
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            #1;
            if (bus16.out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midreset_discard: got %0d valid cycles required 0", seen);
        end
        ra = $urandom;
        rb = $urandom;
        run_one(ra[15:0], rb[15:0], 1'b0, 1'b1, got, lat);
        exp = ref_model(16, longint'(ra[15:0]), longint'(rb[15:0]), 1'b0, 1'b1);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL midreset_next_value: got %h required %h", got, exp);
        end
        n_checks++;
        if (lat != LAT16) begin
            n_fail++;
            $display("FAIL midreset_next_latency: got %0d required %0d", lat, LAT16);
        end
    endtask

    task automatic test_param_sweep();
        int waited = 0;
        sweep_go = 1'b1;
        while (sw_done_cnt < 9 && waited < 30000) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (sw_done_cnt != 9) begin
            n_fail++;
            $display("FAIL sweep_done: got %0d configurations finished required 9", sw_done_cnt);
        end
    endtask

    for (genvar ci = 0; ci < 9; ci++) begin : g_sweep
        localparam int SW = (ci / 3 == 0) ? 4 : ((ci / 3 == 1) ? 12 : 32);
        localparam int SG = (ci % 3) + 1;
        localparam int SL = ((SW / 4) + SG - 1) / SG;

        pipelined_cla_adder_if #(.WIDTH(SW)) sbus ();

        pipelined_cla_adder #(.WIDTH(SW), .GROUPS_PER_STAGE(SG)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (sbus)
        );

        initial begin
            logic [33:0] expq [$];
            int          stampq [$];
            logic [33:0] exp_v;
            logic [33:0] got_v;
            logic [31:0] ra;
            logic [31:0] rb;
            int          sent;
            int          got_n;
            int          cyc;
            int          adv;
            int          lat;
            sbus.in_valid  = 1'b0;
            sbus.A         = '0;
            sbus.B         = '0;
            sbus.Cin       = 1'b0;
            sbus.sub       = 1'b0;
            sbus.out_ready = 1'b0;
            sent  = 0;
            got_n = 0;
            cyc   = 0;
            adv   = 0;
            wait (sweep_go);
            while (got_n < 1000 && cyc < 20000) begin
                @(negedge clk);
                ra = $urandom;
                rb = $urandom;
                sbus.in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
                sbus.A         = ra[SW-1:0];
                sbus.B         = rb[SW-1:0];
                sbus.Cin       = 1'($urandom_range(1));
                sbus.sub       = 1'($urandom_range(1));
                sbus.out_ready = ($urandom_range(2) != 0);
                #1;
                if (sbus.out_valid && sbus.out_ready) begin
                    n_checks++;
                    got_v = {sbus.Ovf, sbus.Cout, 32'(sbus.S)};
                    if (expq.size() == 0) begin
                        n_fail++;
                        $display("FAIL sweep_w%0d_g%0d order: got unexpected %h required none", SW, SG, got_v);
                    end else begin
                        exp_v = expq.pop_front();
                        lat   = adv - stampq.pop_front();
                        if (got_v !== exp_v) begin
                            n_fail++;
                            $display("FAIL sweep_w%0d_g%0d value beat %0d: got %h required %h",
                                     SW, SG, got_n, got_v, exp_v);
                        end
                        n_checks++;
                        if (lat != SL) begin
                            n_fail++;
                            $display("FAIL sweep_w%0d_g%0d latency beat %0d: got %0d required %0d",
                                     SW, SG, got_n, lat, SL);
                        end
                    end
                    got_n++;
                end
                if (sbus.in_valid && sbus.in_ready) begin
                    expq.push_back(ref_model(SW, longint'(sbus.A), longint'(sbus.B), sbus.Cin, sbus.sub));
                    stampq.push_back(adv);
                    sent++;
                end
                // Latency is counted in advancing cycles, so stalls do not count against it.
                if (sbus.in_ready) adv++;
                cyc++;
            end
            sbus.in_valid = 1'b0;
            n_checks++;
            if (got_n != 1000) begin
                n_fail++;
                $display("FAIL sweep_w%0d_g%0d count: got %0d results required 1000", SW, SG, got_n);
            end
            sw_done_cnt++;
        end
    end

    initial begin
        rst = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
